// File: rtl/scan_test_ctrl.sv
// Scan-test initiator: loads patterns into a scan chain, applies one capture cycle,
// unloads each response under the next load and tallies pass/fail per pattern.
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic                 pat_pi,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    input  logic                 pat_exp_po,
    input  logic                 pat_last,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 dut_inp,
    input  logic                 scan_out,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic                 underrun,
    output logic [CNT_W-1:0]     pat_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);
    localparam int SC_W = $clog2(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

    state_t               state_q;
    logic [CHAIN_LEN-2:0] shreg_q;
    logic [CHAIN_LEN-2:0] resp_q;
    logic [SC_W-1:0]      shift_cnt_q;
    logic                 pi_q;
    logic                 exp_po_q;
    logic                 last_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] prev_exp_q;
    logic                 have_resp_q;
    logic                 pend_po_fail_q;
    logic                 flush_q;
    logic                 scan_enable_q;
    logic                 scan_in_q;
    logic                 dut_inp_q;
    logic                 fail_q;
    logic                 underrun_q;
    logic [CNT_W-1:0]     pat_cnt_q;
    logic [CNT_W-1:0]     fail_cnt_q;

    logic                 xfer;
    logic                 last_shift;
    logic [CHAIN_LEN-1:0] resp_word_d;
    logic [CNT_W-1:0]     pat_cnt_d;
    logic [CNT_W-1:0]     fail_cnt_d;

    assign pat_ready   = !rst && ((state_q == IDLE) || (state_q == CAPTURE && !last_q));
    assign xfer        = pat_valid && pat_ready;
    assign last_shift  = (shift_cnt_q == SC_W'(CHAIN_LEN - 1));
    assign resp_word_d = {resp_q, scan_out};
    assign pat_cnt_d   = (&pat_cnt_q)  ? pat_cnt_q  : pat_cnt_q + CNT_W'(1);
    assign fail_cnt_d  = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            resp_q         <= '0;
            shift_cnt_q    <= '0;
            pi_q           <= 1'b0;
            exp_po_q       <= 1'b0;
            last_q         <= 1'b0;
            exp_q          <= '0;
            prev_exp_q     <= '0;
            have_resp_q    <= 1'b0;
            pend_po_fail_q <= 1'b0;
            flush_q        <= 1'b0;
            scan_enable_q  <= 1'b0;
            scan_in_q      <= 1'b0;
            dut_inp_q      <= 1'b0;
            fail_q         <= 1'b0;
            underrun_q     <= 1'b0;
            pat_cnt_q      <= '0;
            fail_cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pat_valid) begin
                        fail_q         <= 1'b0;
                        underrun_q     <= 1'b0;
                        pat_cnt_q      <= '0;
                        fail_cnt_q     <= '0;
                        have_resp_q    <= 1'b0;
                        pend_po_fail_q <= 1'b0;
                        flush_q        <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Response arrives flop CHAIN_LEN-1 first, so it fills from the MSB down.
                    resp_q      <= resp_word_d[CHAIN_LEN-2:0];
                    shreg_q     <= shreg_q << 1;
                    scan_in_q   <= shreg_q[CHAIN_LEN-2];
                    shift_cnt_q <= shift_cnt_q + SC_W'(1);
                    if (last_shift) begin
                        shift_cnt_q   <= '0;
                        scan_enable_q <= 1'b0;
                        scan_in_q     <= 1'b0;
                        if (have_resp_q && ((resp_word_d != prev_exp_q) || pend_po_fail_q)) begin
                            fail_cnt_q <= fail_cnt_d;
                            fail_q     <= 1'b1;
                        end
                        if (flush_q) begin
                            state_q <= DONE;
                        end else begin
                            dut_inp_q <= pi_q;
                            state_q   <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    dut_inp_q      <= 1'b0;
                    pend_po_fail_q <= (dut_out != exp_po_q);
                    pat_cnt_q      <= pat_cnt_d;
                    prev_exp_q     <= exp_q;
                    have_resp_q    <= 1'b1;
                    if (last_q) begin
                        // Flush: shift zeros purely to unload the final response.
                        flush_q       <= 1'b1;
                        shreg_q       <= '0;
                        scan_in_q     <= 1'b0;
                        scan_enable_q <= 1'b1;
                        shift_cnt_q   <= '0;
                        state_q       <= SHIFT;
                    end else if (!pat_valid) begin
                        underrun_q <= 1'b1;
                        fail_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (xfer) begin
                shreg_q       <= pat_data[CHAIN_LEN-2:0];
                pi_q          <= pat_pi;
                exp_q         <= pat_exp;
                exp_po_q      <= pat_exp_po;
                last_q        <= pat_last;
                scan_enable_q <= 1'b1;
                scan_in_q     <= pat_data[CHAIN_LEN-1];
                dut_inp_q     <= 1'b0;
                shift_cnt_q   <= '0;
                state_q       <= SHIFT;
            end
        end
    end

    assign scan_enable = scan_enable_q;
    assign scan_in     = scan_in_q;
    assign dut_inp     = dut_inp_q;
    assign busy        = (state_q == SHIFT) || (state_q == CAPTURE);
    assign done        = (state_q == DONE);
    assign fail        = fail_q;
    assign underrun    = underrun_q;
    assign pat_cnt     = pat_cnt_q;
    assign fail_cnt    = fail_cnt_q;

endmodule
